// File: rtl/sigma_tile_pkg.sv
// Shared types for the sigma tile: MemSplit32 field widths and
// the arbiter index type used by requesters and the tag FIFO.
package sigma_tile_pkg;

    localparam int MS_ADDR_W = 32;
    localparam int MS_DATA_W = 32;
    localparam int MS_BE_W   = 4;

    localparam int ARB_MAX_MASTERS = 4;
    localparam int ARB_ID_W        = $clog2(ARB_MAX_MASTERS);

    typedef logic [ARB_ID_W-1:0] arb_idx_t;

endpackage

// File: rtl/MemSplit32.sv
// Split-transaction 32-bit memory port: request/ack on the
// command side, resp/rdata returned later in issue order.
interface MemSplit32;
    import sigma_tile_pkg::*;

    logic                 req;
    logic                 we;
    logic [MS_ADDR_W-1:0] addr;
    logic [MS_BE_W-1:0]   be;
    logic [MS_DATA_W-1:0] wdata;
    logic                 ack;
    logic                 resp;
    logic [MS_DATA_W-1:0] rdata;

    modport Master (
        output req, we, addr, be, wdata,
        input  ack, resp, rdata
    );

    modport Slave (
        input  req, we, addr, be, wdata,
        output ack, resp, rdata
    );

endinterface

// File: rtl/sfr_arb_tagfifo.sv
// Small FIFO of requester indices for reads awaiting a response.
// Push and pop in one cycle are both honoured, even when full.
module sfr_arb_tagfifo
    import sigma_tile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push,
    input  logic     pop,
    input  arb_idx_t din,
    output arb_idx_t dout,
    output logic     full,
    output logic     empty
);

    localparam int PW = $clog2(DEPTH);

    arb_idx_t      mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (PW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) cnt <= cnt + 1'b1;
            else if (do_pop && !do_push) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/sfr_arb.sv
// Round-robin arbiter sharing one SFR port among NUM_MASTERS
// requesters, routing in-order read responses back by tag.
module sfr_arb
    import sigma_tile_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int TAG_DEPTH   = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_MASTERS-1:0]         m_req_i,
    input  logic [NUM_MASTERS-1:0]         m_we_i,
    input  logic [MS_ADDR_W*NUM_MASTERS-1:0] m_addr_bi,
    input  logic [MS_BE_W*NUM_MASTERS-1:0]   m_be_bi,
    input  logic [MS_DATA_W*NUM_MASTERS-1:0] m_wdata_bi,
    output logic [NUM_MASTERS-1:0]         m_ack_o,
    output logic [NUM_MASTERS-1:0]         m_resp_o,
    output logic [MS_DATA_W-1:0]           m_rdata_bo,
    MemSplit32.Master                      sfr,
    output logic                           err_o
);

    arb_idx_t               rr_ptr;
    arb_idx_t               gnt;
    arb_idx_t               nxt_ptr;
    arb_idx_t               head;
    logic [NUM_MASTERS-1:0] gnt_oh;
    logic                   found;
    logic                   req_v;
    logic                   blocked;
    logic                   xfer;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic                   g_we;
    logic [MS_ADDR_W-1:0]   g_addr;
    logic [MS_BE_W-1:0]     g_be;
    logic [MS_DATA_W-1:0]   g_wdata;

    // first requester at or after rr_ptr, wrapping by index
    always_comb begin
        gnt_oh = '0;
        gnt    = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                if (!found && m_req_i[k] &&
                    k == (int'(rr_ptr) + i) % NUM_MASTERS) begin
                    found     = 1'b1;
                    gnt_oh[k] = 1'b1;
                    gnt       = arb_idx_t'(k);
                end
            end
        end
    end

    always_comb begin
        g_we    = 1'b0;
        g_addr  = '0;
        g_be    = '0;
        g_wdata = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (gnt_oh[k]) begin
                g_we    = m_we_i[k];
                g_addr  = m_addr_bi[k*MS_ADDR_W +: MS_ADDR_W];
                g_be    = m_be_bi[k*MS_BE_W +: MS_BE_W];
                g_wdata = m_wdata_bi[k*MS_DATA_W +: MS_DATA_W];
            end
        end
    end

    assign req_v   = found && rst_i;
    assign blocked = req_v && !g_we && full;
    assign xfer    = sfr.req && sfr.ack;
    assign push    = xfer && !g_we;
    assign pop     = sfr.resp && !empty;
    assign nxt_ptr = (int'(gnt) == NUM_MASTERS - 1) ? '0 : gnt + 1'b1;

    assign sfr.req   = req_v && !blocked;
    assign sfr.we    = g_we;
    assign sfr.addr  = g_addr;
    assign sfr.be    = g_be;
    assign sfr.wdata = g_wdata;

    assign m_ack_o    = xfer ? gnt_oh : '0;
    assign m_rdata_bo = pop ? sfr.rdata : '0;

    always_comb begin
        m_resp_o = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            m_resp_o[k] = pop && (int'(head) == k);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rr_ptr <= '0;
            err_o  <= 1'b0;
        end else begin
            if (xfer) rr_ptr <= nxt_ptr;
            if (sfr.resp && empty) err_o <= 1'b1;
        end
    end

    sfr_arb_tagfifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tagfifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .din   (gnt),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_sfr_arb.sv
// Bench for sfr_arb: scripted stimulus, queue of expected issuers
// checked against each returned response.
module tb_sfr_arb;
    import sigma_tile_pkg::*;

    localparam int NM = 2;
    localparam int TD = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NM-1:0]       m_req = '0;
    logic [NM-1:0]       m_we = '0;
    logic [32*NM-1:0]    m_addr = '0;
    logic [4*NM-1:0]     m_be = '0;
    logic [32*NM-1:0]    m_wdata = '0;
    logic [NM-1:0]       m_ack;
    logic [NM-1:0]       m_resp;
    logic [31:0]         m_rdata;
    logic                err;

    MemSplit32 sfr_bus ();

    sfr_arb #(
        .NUM_MASTERS (NM),
        .TAG_DEPTH   (TD)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .m_req_i    (m_req),
        .m_we_i     (m_we),
        .m_addr_bi  (m_addr),
        .m_be_bi    (m_be),
        .m_wdata_bi (m_wdata),
        .m_ack_o    (m_ack),
        .m_resp_o   (m_resp),
        .m_rdata_bo (m_rdata),
        .sfr        (sfr_bus.Master),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;
    int exp_q[$];
    int mptr;
    int e;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        m_req         = '0;
        sfr_bus.ack   = 1'b0;
        sfr_bus.resp  = 1'b0;
        sfr_bus.rdata = '0;
        tick();
        tick();
        rst = 1'b1;
        exp_q.delete();
        mptr = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sfr_bus.ack   = 1'b0;
        sfr_bus.resp  = 1'b0;
        sfr_bus.rdata = '0;

        // reset state
        @(negedge clk);
        check("rst_ack", 32'(m_ack), 0);
        check("rst_resp", 32'(m_resp), 0);
        check("rst_req", 32'(sfr_bus.req), 0);
        check("rst_err", 32'(err), 0);
        do_reset();

        // alternating reads with 1-cycle responses
        m_we   = '0;
        m_req  = 2'b11;
        m_addr = {32'h20, 32'h10};
        sfr_bus.ack = 1'b1;
        for (int c = 0; c < 8; c++) begin
            sfr_bus.resp  = (exp_q.size() > 0);
            sfr_bus.rdata = 32'hA000_0000 + c;
            @(negedge clk);
            if (sfr_bus.resp) begin
                e = exp_q.pop_front();
                check("alt_resp", 32'(m_resp), 32'(1) << e);
                check("alt_rdata", m_rdata, 32'hA000_0000 + c);
            end
            check("alt_ack", 32'(m_ack), 32'(1) << mptr);
            check("alt_addr", sfr_bus.addr, (mptr == 0) ? 32'h10 : 32'h20);
            exp_q.push_back(mptr);
            mptr = 1 - mptr;
            tick();
        end
        m_req         = '0;
        sfr_bus.resp  = 1'b1;
        sfr_bus.rdata = 32'h1234_5678;
        @(negedge clk);
        e = exp_q.pop_front();
        check("drain_resp", 32'(m_resp), 32'(1) << e);
        check("idle_req", 32'(sfr_bus.req), 0);
        tick();
        sfr_bus.resp = 1'b0;
        @(negedge clk);
        check("alt_err", 32'(err), 0);

        // simultaneous writes
        do_reset();
        m_we    = 2'b11;
        m_req   = 2'b11;
        m_addr  = {32'h4, 32'h4};
        m_wdata = {32'h1, 32'h1};
        m_be    = {4'hC, 4'h3};
        sfr_bus.ack = 1'b1;
        @(negedge clk);
        check("wr_ack0", 32'(m_ack), 1);
        check("wr_wdata0", sfr_bus.wdata, 1);
        check("wr_addr0", sfr_bus.addr, 4);
        check("wr_be0", 32'(sfr_bus.be), 32'h3);
        check("wr_we0", 32'(sfr_bus.we), 1);
        tick();
        m_req = 2'b10;
        @(negedge clk);
        check("wr_ack1", 32'(m_ack), 2);
        check("wr_wdata1", sfr_bus.wdata, 1);
        check("wr_be1", 32'(sfr_bus.be), 32'hC);
        tick();
        m_req = '0;
        @(negedge clk);
        check("wr_idle_req", 32'(sfr_bus.req), 0);
        check("wr_idle_ack", 32'(m_ack), 0);

        // fill tag FIFO, stall, then pop and refill together
        do_reset();
        m_we  = '0;
        m_req = 2'b11;
        sfr_bus.ack = 1'b1;
        for (int c = 0; c < TD; c++) begin
            @(negedge clk);
            check("fill_ack", 32'(m_ack), 32'(1) << mptr);
            exp_q.push_back(mptr);
            mptr = 1 - mptr;
            tick();
        end
        @(negedge clk);
        check("full_ack", 32'(m_ack), 0);
        check("full_req", 32'(sfr_bus.req), 0);
        tick();
        sfr_bus.resp  = 1'b1;
        sfr_bus.rdata = 32'h55;
        @(negedge clk);
        e = exp_q.pop_front();
        check("full_resp", 32'(m_resp), 32'(1) << e);
        check("full_rdata", m_rdata, 32'h55);
        check("full_ack_hold", 32'(m_ack), 0);
        tick();
        sfr_bus.rdata = 32'h66;
        @(negedge clk);
        e = exp_q.pop_front();
        check("swap_resp", 32'(m_resp), 32'(1) << e);
        check("swap_ack", 32'(m_ack), 32'(1) << mptr);
        exp_q.push_back(mptr);
        mptr = 1 - mptr;
        tick();
        m_req = '0;
        while (exp_q.size() > 0) begin
            sfr_bus.rdata = 32'h70 + exp_q.size();
            @(negedge clk);
            e = exp_q.pop_front();
            check("order_resp", 32'(m_resp), 32'(1) << e);
            tick();
        end
        @(negedge clk);
        check("extra_resp", 32'(m_resp), 0);
        tick();
        sfr_bus.resp = 1'b0;
        @(negedge clk);
        check("occ_err", 32'(err), 1);

        // response with nothing outstanding
        do_reset();
        sfr_bus.resp  = 1'b1;
        sfr_bus.rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("orphan_resp", 32'(m_resp), 0);
        tick();
        sfr_bus.resp = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("err_sticky", 32'(err), 1);
            tick();
        end

        // reset with reads outstanding
        do_reset();
        m_we  = '0;
        m_req = 2'b11;
        sfr_bus.ack = 1'b1;
        tick();
        tick();
        tick();
        rst           = 1'b0;
        sfr_bus.resp  = 1'b1;
        sfr_bus.rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("mid_rst_ack", 32'(m_ack), 0);
        check("mid_rst_resp", 32'(m_resp), 0);
        check("mid_rst_req", 32'(sfr_bus.req), 0);
        check("mid_rst_rdata", m_rdata, 0);
        check("mid_rst_err", 32'(err), 0);
        tick();
        rst   = 1'b1;
        m_req = '0;
        @(negedge clk);
        check("post_rst_resp", 32'(m_resp), 0);
        tick();
        sfr_bus.resp = 1'b0;
        m_req = 2'b11;
        @(negedge clk);
        check("post_rst_err", 32'(err), 1);
        check("post_rst_ptr", 32'(m_ack), 1);
        tick();
        m_req = '0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
